// File: rtl/ctrl_decode_pipe.sv
// ID stage: opcode decode, load-use hazard detection and the ID/EX pipeline
// register. It also keeps a sticky illegal-opcode flag and a saturating
// bubble counter.
module ctrl_decode_pipe #(
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned EN_JUMP = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [6:0]         opcode,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [4:0]         rd,
  input  logic               stall,
  input  logic               flush,
  input  logic               illegal_clr,
  output logic               ex_valid,
  output logic               ex_ALUSrc,
  output logic               ex_MemtoReg,
  output logic               ex_RegWrite,
  output logic               ex_MemRead,
  output logic               ex_MemWrite,
  output logic               ex_Branch,
  output logic               ex_Jump,
  output logic [ALUOP_W-1:0] ex_ALUop,
  output logic [4:0]         ex_rd,
  output logic               hazard_stall,
  output logic               illegal,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam logic [6:0] OP_NOP   = 7'b0000000;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // Control bit order: {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump}
  logic [6:0]         dec_ctl;
  logic [2:0]         dec_alu;
  logic               dec_legal;
  logic               jump_en;

  logic               ex_valid_q, ex_valid_d;
  logic [6:0]         ex_ctl_q, ex_ctl_d;
  logic [ALUOP_W-1:0] ex_aluop_q, ex_aluop_d;
  logic [4:0]         ex_rd_q, ex_rd_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;

  assign jump_en = (EN_JUMP != 0);

  // Combinational opcode decode into control word and 3-bit ALU class.
  always_comb begin
    dec_ctl   = '0;
    dec_alu   = 3'b000;
    dec_legal = 1'b1;
    case (opcode)
      OP_NOP: ;
      OP_LW:  dec_ctl = 7'b1111000;
      OP_SW:  dec_ctl = 7'b1000100;
      OP_R:   begin dec_ctl = 7'b0010000; dec_alu = 3'b010; end
      OP_I:   begin dec_ctl = 7'b1010000; dec_alu = 3'b011; end
      OP_BR:  begin dec_ctl = 7'b0000010; dec_alu = 3'b101; end
      OP_JAL: begin
        if (jump_en) dec_ctl = 7'b0010001;
        else         dec_legal = 1'b0;
      end
      OP_JALR: begin
        if (jump_en) dec_ctl = 7'b1010001;
        else         dec_legal = 1'b0;
      end
      OP_LUI: begin
        if (jump_en) begin dec_ctl = 7'b1010000; dec_alu = 3'b100; end
        else         dec_legal = 1'b0;
      end
      OP_AUIPC: begin
        if (jump_en) begin dec_ctl = 7'b1010000; dec_alu = 3'b110; end
        else         dec_legal = 1'b0;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Load-use hazard: the instruction in EX is a load whose destination feeds IF/ID.
  always_comb begin
    hazard_stall = ex_valid_q & ex_ctl_q[3] & (ex_rd_q != 5'd0) & in_valid &
                   ((ex_rd_q == rs1) | (ex_rd_q == rs2));
  end

  // ID/EX next state: flush > stall > hazard bubble > load.
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_ctl_d     = ex_ctl_q;
    ex_aluop_d   = ex_aluop_q;
    ex_rd_d      = ex_rd_q;
    bubble_cnt_d = bubble_cnt_q;
    illegal_d    = illegal_q & ~illegal_clr;
    if (flush) begin
      ex_valid_d = 1'b0;
      ex_ctl_d   = '0;
      ex_aluop_d = '0;
      ex_rd_d    = '0;
    end else if (stall) begin
      // hold everything
    end else if (hazard_stall) begin
      ex_valid_d = 1'b0;
      ex_ctl_d   = '0;
      ex_aluop_d = '0;
      ex_rd_d    = '0;
      if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end else if (in_valid && dec_legal) begin
      ex_valid_d = 1'b1;
      ex_ctl_d   = dec_ctl;
      ex_aluop_d = ALUOP_W'(dec_alu);
      ex_rd_d    = rd;
    end else begin
      ex_valid_d = 1'b0;
      ex_ctl_d   = '0;
      ex_aluop_d = '0;
      ex_rd_d    = '0;
      if (in_valid) illegal_d = 1'b1;
    end
  end

  // Pipeline register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_ctl_q     <= '0;
      ex_aluop_q   <= '0;
      ex_rd_q      <= '0;
      illegal_q    <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_ctl_q     <= ex_ctl_d;
      ex_aluop_q   <= ex_aluop_d;
      ex_rd_q      <= ex_rd_d;
      illegal_q    <= illegal_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_ALUSrc   = ex_ctl_q[6];
  assign ex_MemtoReg = ex_ctl_q[5];
  assign ex_RegWrite = ex_ctl_q[4];
  assign ex_MemRead  = ex_ctl_q[3];
  assign ex_MemWrite = ex_ctl_q[2];
  assign ex_Branch   = ex_ctl_q[1];
  assign ex_Jump     = ex_ctl_q[0];
  assign ex_ALUop    = ex_aluop_q;
  assign ex_rd       = ex_rd_q;
  assign illegal     = illegal_q;
  assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Scoreboard bench for ctrl_decode_pipe. Three instances share one input
// stream: default config, EN_JUMP=0, and CNT_W=2 with a widened ALUop.
module tb_ctrl_decode_pipe;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IA = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111,
                         NOP = 7'b0000000;

  typedef struct packed {
    logic        v;
    logic [6:0]  ctl;  // {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump}
    logic [2:0]  alu;
    logic [4:0]  rd;
    logic        ill;
    logic [15:0] cnt;
  } st_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, stall = 1'b0, flush = 1'b0, illegal_clr = 1'b0;
  logic [6:0]  opcode = '0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;

  logic        o_v[3], o_haz[3], o_ill[3];
  logic [6:0]  o_ctl[3];
  logic [31:0] o_alu[3], o_cnt[3];
  logic [4:0]  o_rd[3];

  int n_checks = 0;
  int n_err = 0;

  st_t mdl[3];
  st_t sb_q[3][$];
  int  cfg_ej[3]  = '{1, 0, 1};
  int  cfg_max[3] = '{65535, 65535, 3};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned EJ = (g == 1) ? 0 : 1;
    localparam int unsigned CW = (g == 2) ? 2 : 16;
    localparam int unsigned AW = (g == 2) ? 5 : 3;
    logic          v, as, m2r, rw, mr, mw, bb, jp, hz, il;
    logic [AW-1:0] alu;
    logic [4:0]    rdo;
    logic [CW-1:0] cnt;
    ctrl_decode_pipe #(.ALUOP_W(AW), .CNT_W(CW), .EN_JUMP(EJ)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opcode(opcode),
      .rs1(rs1), .rs2(rs2), .rd(rd), .stall(stall), .flush(flush),
      .illegal_clr(illegal_clr), .ex_valid(v), .ex_ALUSrc(as),
      .ex_MemtoReg(m2r), .ex_RegWrite(rw), .ex_MemRead(mr), .ex_MemWrite(mw),
      .ex_Branch(bb), .ex_Jump(jp), .ex_ALUop(alu), .ex_rd(rdo),
      .hazard_stall(hz), .illegal(il), .bubble_cnt(cnt)
    );
    assign o_v[g]   = v;
    assign o_ctl[g] = {as, m2r, rw, mr, mw, bb, jp};
    assign o_alu[g] = 32'(alu);
    assign o_rd[g]  = rdo;
    assign o_haz[g] = hz;
    assign o_ill[g] = il;
    assign o_cnt[g] = 32'(cnt);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference decode table: legal flag, control bits, ALU class.
  function automatic void ref_decode(input logic [6:0] op, input int ej,
                                     output bit legal, output logic [6:0] ctl,
                                     output logic [2:0] alu);
    legal = 1; ctl = '0; alu = '0;
    case (op)
      NOP:   ;
      LW:    ctl = 7'b1111000;
      SW:    ctl = 7'b1000100;
      RT:    begin ctl = 7'b0010000; alu = 3'd2; end
      IA:    begin ctl = 7'b1010000; alu = 3'd3; end
      BR:    begin ctl = 7'b0000010; alu = 3'd5; end
      JAL:   if (ej != 0) ctl = 7'b0010001; else legal = 0;
      JALR:  if (ej != 0) ctl = 7'b1010001; else legal = 0;
      LUI:   if (ej != 0) begin ctl = 7'b1010000; alu = 3'd4; end else legal = 0;
      AUIPC: if (ej != 0) begin ctl = 7'b1010000; alu = 3'd6; end else legal = 0;
      default: legal = 0;
    endcase
  endfunction

  function automatic bit ref_hazard(input st_t s);
    return s.v && s.ctl[3] && (s.rd != 0) && in_valid && (s.rd == rs1 || s.rd == rs2);
  endfunction

  function automatic st_t ref_step(input st_t s, input int ej, input int cmax);
    st_t n;
    bit lg; logic [6:0] c; logic [2:0] a;
    n = s;
    n.ill = s.ill & ~illegal_clr;
    ref_decode(opcode, ej, lg, c, a);
    if (flush) begin
      n.v = 0; n.ctl = '0; n.alu = '0; n.rd = '0;
    end else if (stall) begin
    end else if (ref_hazard(s)) begin
      n.v = 0; n.ctl = '0; n.alu = '0; n.rd = '0;
      if (int'(s.cnt) < cmax) n.cnt = s.cnt + 1;
    end else if (in_valid && lg) begin
      n.v = 1; n.ctl = c; n.alu = a; n.rd = rd;
    end else begin
      n.v = 0; n.ctl = '0; n.alu = '0; n.rd = '0;
      if (in_valid) n.ill = 1;
    end
    return n;
  endfunction

  task automatic chk_zero(input int k, input string tag);
    chk($sformatf("%s_d%0d_valid", tag, k), 32'(o_v[k]), 0);
    chk($sformatf("%s_d%0d_ctl", tag, k), 32'(o_ctl[k]), 0);
    chk($sformatf("%s_d%0d_aluop", tag, k), o_alu[k], 0);
    chk($sformatf("%s_d%0d_rd", tag, k), 32'(o_rd[k]), 0);
    chk($sformatf("%s_d%0d_illegal", tag, k), 32'(o_ill[k]), 0);
    chk($sformatf("%s_d%0d_cnt", tag, k), o_cnt[k], 0);
    chk($sformatf("%s_d%0d_hazard", tag, k), 32'(o_haz[k]), 0);
  endtask

  // One clock of stimulus; the expected post-edge state goes to the scoreboard.
  task automatic cycle(input logic iv, input logic [6:0] op, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rdd, input logic st,
                       input logic fl, input logic clr, input logic prst);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = iv; opcode = op; rs1 = r1; rs2 = r2; rd = rdd;
    stall = st; flush = fl; illegal_clr = clr;
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("hazard_d%0d", k), 32'(o_haz[k]), 32'(ref_hazard(mdl[k])));
    if (prst) begin
      #1;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
        chk_zero(k, "async_rst");
        mdl[k] = '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) mdl[k] = ref_step(mdl[k], cfg_ej[k], cfg_max[k]);
    end
    for (int k = 0; k < 3; k++) sb_q[k].push_back(mdl[k]);
  endtask

  // Monitor: after each active edge, compare registered outputs to the queue head.
  always @(posedge clk) begin
    st_t e;
    #1;
    if (sb_q[0].size() != 0) begin
      for (int k = 0; k < 3; k++) begin
        e = sb_q[k].pop_front();
        chk($sformatf("d%0d_valid", k), 32'(o_v[k]), 32'(e.v));
        chk($sformatf("d%0d_ctl", k), 32'(o_ctl[k]), 32'(e.ctl));
        chk($sformatf("d%0d_aluop", k), o_alu[k], 32'(e.alu));
        chk($sformatf("d%0d_rd", k), 32'(o_rd[k]), 32'(e.rd));
        chk($sformatf("d%0d_illegal", k), 32'(o_ill[k]), 32'(e.ill));
        chk($sformatf("d%0d_cnt", k), o_cnt[k], 32'(e.cnt));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops[10];
    ops = '{NOP, LW, SW, RT, IA, BR, JAL, JALR, LUI, AUIPC};
    for (int k = 0; k < 3; k++) mdl[k] = '0;
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk_zero(k, "reset");

    // lw rd=5, then dependent add (bubble), then add loads
    cycle(1, LW, 0, 0, 5, 0, 0, 0, 0);
    cycle(1, RT, 1, 5, 6, 0, 0, 0, 0);
    cycle(1, RT, 1, 5, 6, 0, 0, 0, 0);
    // flush overrides hazard with sw in IF/ID
    cycle(1, LW, 0, 0, 7, 0, 0, 0, 0);
    cycle(1, SW, 7, 0, 0, 0, 1, 0, 0);
    // load I-arith, then hold three cycles under stall
    cycle(1, IA, 0, 0, 3, 0, 0, 0, 0);
    repeat (3) cycle(1, BR, 3, 3, 9, 1, 0, 0, 0);
    // JAL illegal only where jumps are disabled; clear loses to new illegal
    cycle(1, JAL, 0, 0, 1, 0, 0, 0, 0);
    cycle(1, JAL, 0, 0, 1, 0, 0, 1, 0);
    cycle(1, NOP, 0, 0, 0, 0, 0, 1, 0);
    cycle(1, 7'b1111111, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 7'b1111111, 0, 0, 0, 0, 0, 1, 0);
    // alternating load/bubble: five bubbles saturates the 2-bit counter
    repeat (10) cycle(1, LW, 2, 0, 2, 0, 0, 0, 0);
    // async reset in the middle of a stall
    cycle(1, LW, 0, 0, 5, 0, 0, 0, 0);
    cycle(1, RT, 5, 0, 4, 1, 0, 0, 0);
    cycle(1, RT, 5, 0, 4, 1, 0, 0, 1);
    cycle(1, LUI, 0, 0, 8, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [6:0] op;
      if ($urandom_range(0, 7) == 0) op = 7'($urandom);
      else op = ops[$urandom_range(0, 9)];
      cycle(($urandom_range(0, 99) < 85), op,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 10),
            ($urandom_range(0, 99) < 10), ($urandom_range(0, 299) == 0));
    end

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(sb_q[0].size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
